seg7_bcd_display_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_bcd_display_ctrl_if.sv | 30 +++
 rtl/bcd_dabble_seq.sv | 44 ++++
 rtl/seg7_bcd_display_ctrl.sv | 109 ++++++++++
 tb/tb_seg7_bcd_display_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD seven-segment display controller.
package seg7_pkg;

  localparam int unsigned BIN_W      = 12;
  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned SR_W       = BIN_W + BCD_W;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StUpdate
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, index 0 is digit 0.
  localparam logic [9:0][6:0] SEG_PAT = {
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };

  function automatic logic [6:0] seg_lookup(logic [3:0] digit);
    return (digit <= 4'd9) ? SEG_PAT[digit] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/seg7_bcd_display_ctrl_if.sv
// Valid/ready value input plus conversion status/result of the display controller.
interface seg7_bcd_display_ctrl_if;
  import seg7_pkg::*;

  logic [BIN_W-1:0] bin_in;
  logic             bin_valid;
  logic             bin_ready;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] bcd_out;

  modport master (
    output bin_in,
    output bin_valid,
    input  bin_ready,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  bin_in,
    input  bin_valid,
    output bin_ready,
    output busy,
    output done,
    output bcd_out
  );

endinterface

// File: rtl/bcd_dabble_seq.sv
// Iterative shift-add-3 binary-to-BCD datapath, one bit per cycle while run is high.
module bcd_dabble_seq
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] result,
  output logic             finish
);

  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] adj;
  logic [3:0]      cnt_q;

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sr_q  <= {{BCD_W{1'b0}}, bin};
      cnt_q <= '0;
    end else if (run) begin
      sr_q  <= adj << 1;
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // High in the cycle that performs the last shift.
  assign finish = run && (cnt_q == 4'(BIN_W - 1));
  assign result = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg7_bcd_display_ctrl.sv
// Binary-to-BCD conversion FSM with a multiplexed 4-digit common-anode display.
// Optional SEG7_LZ_BLANK_EN: blank leading zeros in the upper three digits.
module seg7_bcd_display_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  seg7_bcd_display_ctrl_if.slave  bus,
  output logic [3:0]              an,
  output logic [6:0]              seg
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  state_e           state_q;
  logic             done_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] disp_q;
  logic             start;
  logic             run;
  logic             finish;
  logic [BCD_W-1:0] result;

  assign start = (state_q == StIdle) && bus.bin_valid;
  assign run   = (state_q == StConvert);

  bcd_dabble_seq u_dabble (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .run    (run),
    .bin    (bus.bin_in),
    .result (result),
    .finish (finish)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      disp_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle:    if (bus.bin_valid) state_q <= StConvert;
        StConvert: if (finish) state_q <= StUpdate;
        StUpdate: begin
          bcd_q   <= result;
          disp_q  <= result;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign bus.bin_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.bcd_out   = bcd_q;

  // Display scan: free-running, never restarted by a new result.
  logic [CntW-1:0] refresh_q;
  logic [1:0]      idx_q;
  logic [3:0]      digit;
  logic [3:0]      an_d;
  logic [6:0]      seg_d;
  logic            blank;

  always_comb begin
    digit = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LZ_BLANK_EN
    case (idx_q)
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      2'd2:    blank = (disp_q[15:8] == 8'd0);
      2'd1:    blank = (disp_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_BLANK : seg_lookup(digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
      an        <= 4'b1110;
      seg       <= SEG_PAT[0];
    end else begin
      if (refresh_q == CntMax) begin
        refresh_q <= '0;
        idx_q     <= idx_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_display_ctrl.sv
// Directed self-checking bench for seg7_bcd_display_ctrl with REFRESH_DIV=4.
module tb_seg7_bcd_display_ctrl;
  import seg7_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] an;
  logic [6:0] seg;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  seg7_bcd_display_ctrl_if bus_if ();

  seg7_bcd_display_ctrl #(
    .REFRESH_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .an  (an),
    .seg (seg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Accept v in the current cycle T, then follow T+1..T+14.
  task automatic convert(input logic [11:0] v, input logic [15:0] exp);
    bus_if.bin_in    = v;
    bus_if.bin_valid = 1'b1;
    chk("accept_ready", 32'(bus_if.bin_ready), 32'd1);
    step(1);
    bus_if.bin_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk("ready", 32'(bus_if.bin_ready), 32'(c == 14));
      chk("busy", 32'(bus_if.busy), 32'(c != 14));
      chk("done", 32'(bus_if.done), 32'(c == 14));
      if (c < 14) step(1);
    end
    chk("bcd_out", 32'(bus_if.bcd_out), 32'(exp));
    step(1);
    chk("done_one_cycle", 32'(bus_if.done), 32'd0);
  endtask

  // Sync to the start of the ones slot, then check 4 slots of 4 cycles each.
  task automatic scan(input string tag, input logic [15:0] an_exp, input logic [27:0] seg_exp);
    logic [3:0] prev;
    bit         found;
    found = 1'b0;
    prev  = an;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = an;
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    if (found) begin
      for (int s = 0; s < 4; s++) begin
        for (int k = 0; k < 4; k++) begin
          chk({tag, "_an"}, 32'(an), 32'(an_exp[s*4 +: 4]));
          chk({tag, "_seg"}, 32'(seg), 32'(seg_exp[s*7 +: 7]));
          step(1);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus_if.bin_valid = 1'b0;
    bus_if.bin_in    = '0;
    step(3);
    rst = 1'b0;
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    chk("rst_ready", 32'(bus_if.bin_ready), 32'd1);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_bcd", 32'(bus_if.bcd_out), 32'h0000);

    convert(12'd1234, 16'h1234);
    scan("scan1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
         {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    convert(12'd4095, 16'h4095);
    convert(12'd0, 16'h0000);
    convert(12'd999, 16'h0999);

    convert(12'd7, 16'h0007);
`ifdef SEG7_LZ_BLANK_EN
    scan("scan7", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
         {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});
`else
    scan("scan7", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
         {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000});
`endif

    // New request held from T+3 must wait until T+14.
    bus_if.bin_in    = 12'd500;
    bus_if.bin_valid = 1'b1;
    step(1);
    bus_if.bin_valid = 1'b0;
    step(2);
    bus_if.bin_in    = 12'd77;
    bus_if.bin_valid = 1'b1;
    for (int c = 3; c <= 14; c++) begin
      chk("ign_ready", 32'(bus_if.bin_ready), 32'(c == 14));
      chk("ign_done", 32'(bus_if.done), 32'(c == 14));
      if (c < 14) step(1);
    end
    chk("ign_bcd", 32'(bus_if.bcd_out), 32'h0500);
    step(1);
    bus_if.bin_valid = 1'b0;
    chk("held_accepted", 32'(bus_if.busy), 32'd1);
    step(12);
    chk("held_done_early", 32'(bus_if.done), 32'd0);
    step(1);
    chk("held_done", 32'(bus_if.done), 32'd1);
    chk("held_bcd", 32'(bus_if.bcd_out), 32'h0077);

    // Reset in the middle of a conversion aborts it.
    step(1);
    bus_if.bin_in    = 12'd321;
    bus_if.bin_valid = 1'b1;
    step(1);
    bus_if.bin_valid = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_ready", 32'(bus_if.bin_ready), 32'd1);
    chk("abort_busy", 32'(bus_if.busy), 32'd0);
    chk("abort_bcd", 32'(bus_if.bcd_out), 32'h0000);
    chk("abort_an", 32'(an), 32'b1110);
    chk("abort_seg", 32'(seg), 32'b1000000);
    for (int c = 0; c < 14; c++) begin
      chk("abort_no_done", 32'(bus_if.done), 32'd0);
      chk("abort_idle", 32'(bus_if.bin_ready), 32'd1);
      step(1);
    end
    chk("abort_bcd_after", 32'(bus_if.bcd_out), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
